// File: rtl/sprite_pkg.sv
// Shared constants, coordinate type and update-FSM states for the sprite mover.
package sprite_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int SPRITE_SIZE = 64;
  localparam int X_MAX       = H_ACTIVE - SPRITE_SIZE;
  localparam int Y_MAX       = V_ACTIVE - SPRITE_SIZE;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } upd_state_t;

endpackage

// File: rtl/sprite_mover_debounce.sv
// Two-flop synchronizer followed by a stability counter; the clean level only
// follows the synced input after it has differed for DEB_CYCLES straight clocks.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  // Any cycle where the synced level agrees with the output restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] != level) begin
      if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// Button-driven sprite position, updated once per frame at the start of vblank.
// Define SPRITE_MOVER_WRAP_EN to wrap at the screen edges instead of clamping.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int STEP       = 4,
  parameter int INIT_X     = 288,
  parameter int INIT_Y     = 208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_en,
  input  logic [9:0] pixelx,
  input  logic [9:0] pixely,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       enable,
  output logic       frame_tick
);

  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] YMAX11 = 11'(Y_MAX);
  localparam coord_t      VBLANK_ROW = coord_t'(V_ACTIVE);

  logic db_up, db_down, db_left, db_right, db_en;
  logic db_en_q;

  upd_state_t state, state_next;

  logic [10:0] nx, ny;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst_n(rst_n), .raw(btn_up), .level(db_up)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst_n(rst_n), .raw(btn_down), .level(db_down)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk(clk), .rst_n(rst_n), .raw(btn_left), .level(db_left)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk(clk), .rst_n(rst_n), .raw(btn_right), .level(db_right)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_en (
    .clk(clk), .rst_n(rst_n), .raw(btn_en), .level(db_en)
  );

  function automatic logic [10:0] step_down(input logic [10:0] cur, input logic [10:0] maxv);
    logic [10:0] r;
`ifdef SPRITE_MOVER_WRAP_EN
    r = cur + maxv + 11'd1 - STEP11;
    if (r > maxv) r = r - (maxv + 11'd1);
`else
    r = (cur < STEP11) ? 11'd0 : cur - STEP11;
`endif
    return r;
  endfunction

  function automatic logic [10:0] step_up(input logic [10:0] cur, input logic [10:0] maxv);
    logic [10:0] r;
    r = cur + STEP11;
`ifdef SPRITE_MOVER_WRAP_EN
    if (r > maxv) r = r - (maxv + 11'd1);
`else
    if (r > maxv) r = maxv;
`endif
    return r;
  endfunction

  // Opposing buttons on one axis cancel; the other axis still moves.
  always_comb begin
    nx = {1'b0, posx};
    ny = {1'b0, posy};
    if (db_left && !db_right) begin
      nx = step_down({1'b0, posx}, XMAX11);
    end else if (db_right && !db_left) begin
      nx = step_up({1'b0, posx}, XMAX11);
    end
    if (db_up && !db_down) begin
      ny = step_down({1'b0, posy}, YMAX11);
    end else if (db_down && !db_up) begin
      ny = step_up({1'b0, posy}, YMAX11);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARMED;
    end else begin
      state <= state_next;
    end
  end

  // DONE waits for the row counter to leave vblank so a slow pixel clock
  // holding row 480 / column 0 for several clk cycles cannot retrigger.
  always_comb begin
    state_next = state;
    frame_tick = 1'b0;
    case (state)
      ARMED: begin
        if (pixely == VBLANK_ROW && pixelx == 10'd0) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        frame_tick = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (pixely < VBLANK_ROW) begin
          state_next = ARMED;
        end
      end
      default: begin
        state_next = ARMED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      posx <= coord_t'(INIT_X);
      posy <= coord_t'(INIT_Y);
    end else if (state == UPDATE) begin
      posx <= nx[9:0];
      posy <= ny[9:0];
    end
  end

  // Enable flips on each accepted press, independent of the frame timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_en_q <= 1'b0;
      enable  <= 1'b1;
    end else begin
      db_en_q <= db_en;
      if (db_en && !db_en_q) begin
        enable <= ~enable;
      end
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover with a short debounce window and a
// hand-stepped pixel counter standing in for the VGA timing generator.
module tb_sprite_mover;

  localparam int STEP   = 4;
  localparam int X_MAX  = 576;
  localparam int Y_MAX  = 416;
  localparam int INIT_X = 288;
  localparam int INIT_Y = 208;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_left, btn_right, btn_en;
  logic [9:0] pixelx, pixely;
  logic [9:0] posx, posy;
  logic       enable, frame_tick;

  int total = 0;
  int bad   = 0;
  int ticks = 0;
  bit watch = 1'b0;
  logic [9:0] prev_y;
  logic       prev_tick;
  int exp_x, exp_y;
  logic bounce;

  sprite_mover #(.DEB_CYCLES(4), .STEP(STEP), .INIT_X(INIT_X), .INIT_Y(INIT_Y)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_en(btn_en),
    .pixelx(pixelx), .pixely(pixely),
    .posx(posx), .posy(posy), .enable(enable), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic u, input logic d, input logic l,
                               input logic r, input logic e);
    btn_up    = u;
    btn_down  = d;
    btn_left  = l;
    btn_right = r;
    btn_en    = e;
  endtask

  // Advance to the next falling edge and sample the outputs there.
  task automatic cycle();
    @(negedge clk);
    if (frame_tick) ticks++;
    if (watch) begin
      checkOutput("posy_only_after_tick", (posy != prev_y && !prev_tick) ? 1 : 0, 0);
    end
    prev_y    = posy;
    prev_tick = frame_tick;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // One frame: active rows, row 479, then row 480 with column 0 held two
  // clocks, more vblank, and back to row 0.
  task automatic run_frame();
    ticks  = 0;
    pixely = 10'd100; pixelx = 10'd5;   run(2);
    pixely = 10'd479; pixelx = 10'd639; run(2);
    pixely = 10'd480; pixelx = 10'd0;   run(2);
    pixelx = 10'd1;                     run(2);
    pixely = 10'd481; pixelx = 10'd0;   run(2);
    pixely = 10'd0;   pixelx = 10'd0;   run(2);
  endtask

  function automatic int move_axis(input int cur, input bit dec, input bit inc, input int maxv);
    int r;
    r = cur;
    if (dec && !inc) begin
`ifdef SPRITE_MOVER_WRAP_EN
      r = (cur >= STEP) ? cur - STEP : cur + maxv + 1 - STEP;
`else
      r = (cur >= STEP) ? cur - STEP : 0;
`endif
    end else if (inc && !dec) begin
`ifdef SPRITE_MOVER_WRAP_EN
      r = (cur + STEP > maxv) ? cur + STEP - (maxv + 1) : cur + STEP;
`else
      r = (cur + STEP > maxv) ? maxv : cur + STEP;
`endif
    end
    return r;
  endfunction

  initial begin
    rst_n     = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pixelx    = 10'd0;
    pixely    = 10'd0;
    prev_y    = 10'd0;
    prev_tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_posx", int'(posx), INIT_X);
    checkOutput("reset_posy", int'(posy), INIT_Y);
    checkOutput("reset_enable", int'(enable), 1);
    checkOutput("reset_tick", int'(frame_tick), 0);
    run(2);
    rst_n = 1'b1;
    exp_x = INIT_X;
    exp_y = INIT_Y;

    $display("[TB] hold right for three frames");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(10);
    for (int f = 0; f < 3; f++) begin
      run_frame();
      exp_x = move_axis(exp_x, 1'b0, 1'b1, X_MAX);
      checkOutput("right_posx", int'(posx), exp_x);
      checkOutput("right_ticks", ticks, 1);
    end

    $display("[TB] asynchronous reset mid-frame");
    pixely = 10'd200; pixelx = 10'd100;
    cycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_posx", int'(posx), INIT_X);
    checkOutput("midreset_posy", int'(posy), INIT_Y);
    checkOutput("midreset_enable", int'(enable), 1);
    checkOutput("midreset_tick", int'(frame_tick), 0);
    cycle();
    rst_n = 1'b1;
    exp_x = INIT_X;
    run(10);
    run_frame();
    exp_x = move_axis(exp_x, 1'b0, 1'b1, X_MAX);
    checkOutput("after_reset_posx", int'(posx), exp_x);
    checkOutput("after_reset_ticks", ticks, 1);

    $display("[TB] right edge");
    for (int f = 0; f < 73; f++) begin
      run_frame();
      exp_x = move_axis(exp_x, 1'b0, 1'b1, X_MAX);
      checkOutput("xedge_posx", int'(posx), exp_x);
      checkOutput("xedge_posy", int'(posy), exp_y);
      checkOutput("xedge_ticks", ticks, 1);
    end

    $display("[TB] top edge");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(10);
    for (int f = 0; f < 54; f++) begin
      run_frame();
      exp_y = move_axis(exp_y, 1'b1, 1'b0, Y_MAX);
      checkOutput("yedge_posy", int'(posy), exp_y);
      checkOutput("yedge_posx", int'(posx), exp_x);
    end

    $display("[TB] bouncing left button");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(10);
    bounce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bounce   = ~bounce;
      btn_left = bounce;
      run(2);
    end
    btn_left = 1'b0;
    run(10);
    run_frame();
    checkOutput("bounce_posx", int'(posx), exp_x);
    checkOutput("bounce_posy", int'(posy), exp_y);

    $display("[TB] left+right with down");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run(10);
    run_frame();
    exp_y = move_axis(exp_y, 1'b0, 1'b1, Y_MAX);
    checkOutput("lr_posx", int'(posx), exp_x);
    checkOutput("lr_posy", int'(posy), exp_y);

    $display("[TB] posy stability while holding down");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(10);
    watch = 1'b1;
    for (int f = 0; f < 3; f++) begin
      run_frame();
      exp_y = move_axis(exp_y, 1'b0, 1'b1, Y_MAX);
      checkOutput("stable_posy", int'(posy), exp_y);
    end
    watch = 1'b0;

    $display("[TB] enable toggle in active region");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(10);
    pixely = 10'd100; pixelx = 10'd50;
    ticks  = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(3);
    checkOutput("en_not_yet", int'(enable), 1);
    run(7);
    checkOutput("en_first_press", int'(enable), 0);
    run(90);
    checkOutput("en_held", int'(enable), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(20);
    checkOutput("en_released", int'(enable), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(10);
    checkOutput("en_second_press", int'(enable), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(10);
    checkOutput("en_second_release", int'(enable), 1);
    checkOutput("stall_ticks", ticks, 0);
    checkOutput("stall_posx", int'(posx), exp_x);
    checkOutput("stall_posy", int'(posy), exp_y);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
